// File: rtl/pcle_pkg.sv
// pcle_pkg: shared constants, the operation-select enum and the modulo
// inc/dec helpers used by the pcle_cnt counter slice.
//
// The helpers work on a fixed 64-bit carrier so that a single package can
// serve any instance width. Callers zero-extend q and truncate the result to
// WIDTH. Wrapping modulo 2^64 and then truncating gives the same result as
// wrapping modulo 2^WIDTH. Supported widths are therefore 2..63. The top bit
// of the carrier is kept free so that the carry/borrow bits above WIDTH always
// exist.
package pcle_pkg;

  // Default counter width, matching the legacy 8-bit slice.
  localparam int PCLE_WIDTH = 8;

  // Width of the arithmetic carrier used by the helper functions.
  localparam int PCLE_MAX_WIDTH = 64;

  // Which source feeds the q register on the next edge, in priority order.
  typedef enum logic [1:0] {
    OP_HOLD  = 2'd0,
    OP_CLR   = 2'd1,
    OP_LOAD  = 2'd2,
    OP_COUNT = 2'd3
  } pcle_op_e;

  // Increment (up=1) or decrement (up=0) on the carrier. The caller truncates
  // the result to its own width to obtain modulo-2^WIDTH behaviour.
  function automatic logic [PCLE_MAX_WIDTH-1:0] next_count(
    input logic [PCLE_MAX_WIDTH-1:0] q,
    input logic                      up
  );
    logic [PCLE_MAX_WIDTH-1:0] one;
    one = PCLE_MAX_WIDTH'(1);
    return up ? (q + one) : (q - one);
  endfunction

  // Terminal value for the given direction: all-ones across 'width' bits when
  // counting up, zero when counting down. The bits above 'width' are zero.
  function automatic logic [PCLE_MAX_WIDTH-1:0] term_val(
    input logic        up,
    input int unsigned width
  );
    logic [PCLE_MAX_WIDTH-1:0] ones;
    ones = '1;
    return up ? (ones >> (PCLE_MAX_WIDTH - width)) : '0;
  endfunction

endpackage : pcle_pkg

// File: rtl/pcle_incdec.sv
// pcle_incdec: combinational WIDTH-bit incrementer/decrementer with terminal
// detect. This is the parametrised form of the legacy 8-bit next-state adder.
// nxt is q+1 or q-1 modulo 2^WIDTH. term flags that q currently sits on the
// value from which the next step in direction 'up' wraps around.
module pcle_incdec
  import pcle_pkg::*;
#(
  parameter int WIDTH = PCLE_WIDTH
) (
  input  logic [WIDTH-1:0] q,
  input  logic             up,
  output logic [WIDTH-1:0] nxt,
  output logic             term
);

  logic [PCLE_MAX_WIDTH-1:0] q_ext;
  logic [PCLE_MAX_WIDTH-1:0] nxt_ext;
  logic [PCLE_MAX_WIDTH-1:0] term_ext;

  // The carry/borrow bits above WIDTH are discarded by the truncation below.
  // They are reduced into this signal only so that they are visibly consumed.
  logic                      unused_hi;

  assign q_ext    = PCLE_MAX_WIDTH'(q);
  assign term_ext = term_val(up, WIDTH);

  // Modulo step and terminal compare, both purely combinational.
  always_comb begin
    nxt_ext   = next_count(q_ext, up);
    nxt       = nxt_ext[WIDTH-1:0];
    term      = (q_ext == term_ext);
    unused_hi = ^nxt_ext[PCLE_MAX_WIDTH-1:WIDTH];
  end

endmodule : pcle_incdec

// File: rtl/pcle_cnt.sv
// pcle_cnt: registered WIDTH-bit up/down counter slice with parallel load,
// count enable/inhibit and a cascade carry chain (tc -> cin).
//
// Next-state priority is sync_clr > load > count > hold. tc is combinational,
// so a chain of N slices has an N-deep ripple from the least-significant
// stage. wrap is a registered one-cycle pulse that follows an actual
// wrap-around. It is suppressed whenever a clear or a load overrides the count.
module pcle_cnt
  import pcle_pkg::*;
#(
  parameter int                        WIDTH     = PCLE_WIDTH,
  parameter logic [PCLE_MAX_WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sync_clr,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic             en,
  input  logic             inhibit,
  input  logic             cin,
  input  logic             up,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap
);

  // RESET_VAL is truncated to the instance width.
  localparam logic [WIDTH-1:0] RST_Q = RESET_VAL[WIDTH-1:0];

  logic             count_ok;
  logic             term;
  logic [WIDTH-1:0] step_q;
  pcle_op_e         op;
  logic [WIDTH-1:0] q_nxt;
  logic             wrap_nxt;

  assign count_ok = en & ~inhibit & cin;

  // Step and terminal detect for the current direction.
  pcle_incdec #(
    .WIDTH (WIDTH)
  ) u_incdec (
    .q    (q),
    .up   (up),
    .nxt  (step_q),
    .term (term)
  );

  // Terminal count for the next stage. It ignores load and sync_clr so that
  // the cascade ripple depends only on the count qualifiers and q.
  assign tc = count_ok & term;

  // Select the source of the next q in priority order.
  always_comb begin
    op = OP_HOLD;
    if (sync_clr) begin
      op = OP_CLR;
    end else if (load) begin
      op = OP_LOAD;
    end else if (count_ok) begin
      op = OP_COUNT;
    end
  end

  // Next-state mux. A wrap is reported only when the count itself is taken.
  always_comb begin
    q_nxt    = q;
    wrap_nxt = 1'b0;
    unique case (op)
      OP_CLR:   q_nxt = '0;
      OP_LOAD:  q_nxt = d;
      OP_COUNT: begin
        q_nxt    = step_q;
        wrap_nxt = term;
      end
      default:  q_nxt = q;
    endcase
  end

  // Count and wrap registers. The asynchronous reset takes effect at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q    <= RST_Q;
      wrap <= 1'b0;
    end else begin
      q    <= q_nxt;
      wrap <= wrap_nxt;
    end
  end

endmodule : pcle_cnt

// File: tb/tb_pcle_cnt.sv
// tb_pcle_cnt: directed bench for pcle_cnt. It uses one standalone 8-bit
// slice and a two-slice 16-bit cascade. Inputs change and outputs are sampled
// 1 time unit after the rising edge. Expected values are hand-computed.
module tb_pcle_cnt;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // ---------------- single slice ----------------
  logic       sync_clr, load, en, inhibit, cin, up;
  logic [7:0] d, q;
  logic       tc, wrap;

  pcle_cnt #(.WIDTH(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .sync_clr (sync_clr),
    .load     (load),
    .d        (d),
    .en       (en),
    .inhibit  (inhibit),
    .cin      (cin),
    .up       (up),
    .q        (q),
    .tc       (tc),
    .wrap     (wrap)
  );

  // ---------------- cascade: lo.tc -> hi.cin ----------------
  logic       c_load, c_en;
  logic [7:0] c_d_lo, c_d_hi, lo_q, hi_q;
  logic       lo_tc, hi_tc, lo_wrap, hi_wrap;
  logic       c_zero = 1'b0;
  logic       c_one  = 1'b1;

  pcle_cnt #(.WIDTH(8)) u_lo (
    .clk      (clk),
    .rst      (rst),
    .sync_clr (c_zero),
    .load     (c_load),
    .d        (c_d_lo),
    .en       (c_en),
    .inhibit  (c_zero),
    .cin      (c_one),
    .up       (c_one),
    .q        (lo_q),
    .tc       (lo_tc),
    .wrap     (lo_wrap)
  );

  pcle_cnt #(.WIDTH(8)) u_hi (
    .clk      (clk),
    .rst      (rst),
    .sync_clr (c_zero),
    .load     (c_load),
    .d        (c_d_hi),
    .en       (c_en),
    .inhibit  (c_zero),
    .cin      (lo_tc),
    .up       (c_one),
    .q        (hi_q),
    .tc       (hi_tc),
    .wrap     (hi_wrap)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];
  logic       exp_wrap_q[$];

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pop the next expected q/wrap pair and compare against the single slice.
  task automatic sb_check(input string tag);
    logic [7:0] eq;
    logic       ew;
    if (exp_q.size() == 0 || exp_wrap_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s: observed empty queue expected entry", tag);
    end else begin
      eq = exp_q.pop_front();
      ew = exp_wrap_q.pop_front();
      check({tag, ".q"}, 16'(q), 16'(eq));
      check({tag, ".wrap"}, 16'(wrap), 16'(ew));
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_val(input logic [7:0] v);
    en = 1'b0; sync_clr = 1'b0; load = 1'b1; d = v;
    tick();
    load = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    sync_clr = 0; load = 0; d = 0; en = 0; inhibit = 0; cin = 1; up = 1;
    c_load = 0; c_en = 0; c_d_lo = 0; c_d_hi = 0;

    // Reset state
    #1 rst = 1'b1;
    #1;
    check("rst.q", 16'(q), 16'h00);
    check("rst.wrap", 16'(wrap), 16'h0);
    check("rst.tc", 16'(tc), 16'h0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Reset mid-count: reach 0x5C, then reset between edges
    load_val(8'h5A);
    check("ld5a.q", 16'(q), 16'h5A);
    en = 1; cin = 1; up = 1;
    tick();
    tick();
    check("cnt.q", 16'(q), 16'h5C);
    #3 rst = 1'b1;
    #1;
    check("rstmid.q", 16'(q), 16'h00);
    check("rstmid.wrap", 16'(wrap), 16'h0);
    #1 rst = 1'b0;
    tick();
    check("resume.q", 16'(q), 16'h01);

    // Load priority
    load_val(8'h10);
    en = 1; load = 1; d = 8'hA5;
    tick();
    check("ldpri.q", 16'(q), 16'hA5);
    check("ldpri.wrap", 16'(wrap), 16'h0);
    sync_clr = 1; load = 1; d = 8'h3C;
    tick();
    check("clrpri.q", 16'(q), 16'h00);
    sync_clr = 0; load = 0;

    // Up wrap
    load_val(8'hFE);
    en = 1; cin = 1; up = 1;
    #1;
    check("upfe.tc", 16'(tc), 16'h0);
    exp_q.push_back(8'hFF); exp_wrap_q.push_back(1'b0);
    exp_q.push_back(8'h00); exp_wrap_q.push_back(1'b1);
    exp_q.push_back(8'h01); exp_wrap_q.push_back(1'b0);
    tick();
    sb_check("up1");
    check("upff.tc", 16'(tc), 16'h1);
    tick();
    sb_check("up2");
    check("up00.tc", 16'(tc), 16'h0);
    tick();
    sb_check("up3");

    // Down wrap
    load_val(8'h01);
    en = 1; up = 0;
    exp_q.push_back(8'h00); exp_wrap_q.push_back(1'b0);
    exp_q.push_back(8'hFF); exp_wrap_q.push_back(1'b1);
    exp_q.push_back(8'hFE); exp_wrap_q.push_back(1'b0);
    tick();
    sb_check("dn1");
    check("dn00.tc", 16'(tc), 16'h1);
    tick();
    sb_check("dn2");
    tick();
    sb_check("dn3");

    // tc ignores load, and load over a wrapping count yields no wrap
    load_val(8'h00);
    en = 1; up = 0; load = 1; d = 8'h55;
    #1;
    check("ldtc.tc", 16'(tc), 16'h1);
    tick();
    check("ldwrap.q", 16'(q), 16'h55);
    check("ldwrap.wrap", 16'(wrap), 16'h0);
    load = 0;

    // Direction change mid-stream
    load_val(8'h80);
    en = 1; up = 1;
    tick();
    check("dir.up", 16'(q), 16'h81);
    up = 0;
    tick();
    check("dir.dn", 16'(q), 16'h80);

    // Inhibit gating
    load_val(8'h37);
    en = 1; inhibit = 1; cin = 1; up = 1;
    for (int i = 0; i < 5; i++) tick();
    check("inh.q", 16'(q), 16'h37);
    check("inh.tc", 16'(tc), 16'h0);
    load_val(8'hFF);
    en = 1; inhibit = 1;
    #1;
    check("inhff.tc", 16'(tc), 16'h0);
    tick();
    check("inhff.q", 16'(q), 16'hFF);
    check("inhff.wrap", 16'(wrap), 16'h0);

    // Carry-in gating
    inhibit = 0; cin = 0;
    for (int i = 0; i < 5; i++) tick();
    check("cin.q", 16'(q), 16'hFF);
    check("cin.tc", 16'(tc), 16'h0);
    cin = 1;
    #1;
    check("cin1.tc", 16'(tc), 16'h1);

    // Reset clears a live wrap pulse and overrides a pending load
    tick();
    check("wrapset", 16'(wrap), 16'h1);
    rst = 1'b1;
    #1;
    check("rstwrap.wrap", 16'(wrap), 16'h0);
    rst = 1'b0;
    load_val(8'h44);
    load = 1; d = 8'hAA; en = 0;
    #2 rst = 1'b1;
    #1;
    check("rstld.q", 16'(q), 16'h00);
    tick();
    check("rstld.hold", 16'(q), 16'h00);
    rst = 1'b0;
    load = 0;

    // Cascade
    c_load = 1; c_d_lo = 8'hFF; c_d_hi = 8'h00;
    tick();
    c_load = 0; c_en = 1;
    #1;
    check("cas.lo_tc", 16'(lo_tc), 16'h1);
    check("cas.hi_tc", 16'(hi_tc), 16'h0);
    tick();
    check("cas.q", {hi_q, lo_q}, 16'h0100);
    check("cas.lo_wrap", 16'(lo_wrap), 16'h1);
    check("cas.hi_wrap", 16'(hi_wrap), 16'h0);
    c_en = 0; c_load = 1; c_d_lo = 8'hFF; c_d_hi = 8'hFF;
    tick();
    c_load = 0; c_en = 1;
    #1;
    check("casff.hi_tc", 16'(hi_tc), 16'h1);
    tick();
    check("casff.q", {hi_q, lo_q}, 16'h0000);
    check("casff.lo_wrap", 16'(lo_wrap), 16'h1);
    check("casff.hi_wrap", 16'(hi_wrap), 16'h1);
    tick();
    check("casnext.q", {hi_q, lo_q}, 16'h0001);
    check("casnext.hi_wrap", 16'(hi_wrap), 16'h0);

    // Final report
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_pcle_cnt
